// File: rtl/modexp_sequencer.sv
// Left-to-right square-and-multiply modular exponentiation sequencing one external Montgomery multiplier.
// Optional MODEXP_SKIP_LEADING_ZEROS_EN: SCAN skips leading zero exponent bits before squaring starts.
module modexp_sequencer #(
  parameter int DATA_W = 1024,
  parameter int EXP_W  = 1024
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              start,
  input  logic [DATA_W-1:0] in_x,
  input  logic [EXP_W-1:0]  in_e,
  input  logic [DATA_W-1:0] in_m,
  input  logic [DATA_W-1:0] in_r2,
  input  logic [DATA_W-1:0] in_rmodm,
  output logic [DATA_W-1:0] result,
  output logic              done,
  output logic              busy,
  output logic              mm_start,
  output logic [DATA_W-1:0] mm_a,
  output logic [DATA_W-1:0] mm_b,
  output logic [DATA_W-1:0] mm_m,
  input  logic [DATA_W-1:0] mm_result,
  input  logic              mm_done
);

  localparam int IDX_W = (EXP_W > 1) ? $clog2(EXP_W) : 1;

  typedef enum logic [2:0] {
    S_IDLE, S_TOMONT, S_SCAN, S_SQUARE, S_MULT, S_NEXT, S_FROMMONT, S_DONE
  } state_t;

  state_t             r_state, w_next;
  logic [EXP_W-1:0]   r_e;
  logic [IDX_W-1:0]   r_idx;
  logic [DATA_W-1:0]  r_a, r_xm;
  logic               w_op_done, w_issue, w_idx_dec, w_ebit;
  logic [DATA_W-1:0]  w_op_a, w_op_b;

  // mm_start marks the issue cycle; a completion is only honoured after it.
  assign w_op_done = mm_done & ~mm_start;
  assign w_ebit    = r_e[r_idx];
  assign done      = (r_state == S_DONE);
  assign busy      = (r_state != S_IDLE);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) r_state <= S_IDLE;
    else         r_state <= w_next;
  end

  always_comb begin
    w_next    = r_state;
    w_issue   = 1'b0;
    w_idx_dec = 1'b0;
    w_op_a    = r_a;
    w_op_b    = r_a;
    case (r_state)
      S_IDLE: if (start) begin
        w_next  = S_TOMONT;
        w_issue = 1'b1;
        w_op_a  = in_x;
        w_op_b  = in_r2;
      end
      S_TOMONT: if (w_op_done) w_next = S_SCAN;
      S_SCAN: begin
`ifdef MODEXP_SKIP_LEADING_ZEROS_EN
        if (!w_ebit && r_idx != '0) begin
          w_idx_dec = 1'b1;
        end else if (!w_ebit) begin
          w_next  = S_FROMMONT;
          w_issue = 1'b1;
          w_op_b  = DATA_W'(1);
        end else begin
          w_next  = S_SQUARE;
          w_issue = 1'b1;
        end
`else
        w_next  = S_SQUARE;
        w_issue = 1'b1;
`endif
      end
      S_SQUARE: if (w_op_done) begin
        if (w_ebit) begin
          w_next  = S_MULT;
          w_issue = 1'b1;
          w_op_a  = mm_result;
          w_op_b  = r_xm;
        end else begin
          w_next = S_NEXT;
        end
      end
      S_MULT: if (w_op_done) w_next = S_NEXT;
      S_NEXT: begin
        w_issue = 1'b1;
        if (r_idx == '0) begin
          w_next = S_FROMMONT;
          w_op_b = DATA_W'(1);
        end else begin
          w_next    = S_SQUARE;
          w_idx_dec = 1'b1;
        end
      end
      S_FROMMONT: if (w_op_done) w_next = S_DONE;
      S_DONE:     w_next = S_IDLE;
      default:    w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      mm_start <= 1'b0;
      mm_a     <= '0;
      mm_b     <= '0;
      mm_m     <= '0;
      result   <= '0;
      r_e      <= '0;
      r_idx    <= '0;
      r_a      <= '0;
      r_xm     <= '0;
    end else begin
      mm_start <= w_issue;
      if (w_issue) begin
        mm_a <= w_op_a;
        mm_b <= w_op_b;
      end
      if (r_state == S_IDLE && start) begin
        r_e   <= in_e;
        r_a   <= in_rmodm;
        r_idx <= IDX_W'(EXP_W - 1);
        mm_m  <= in_m;
      end
      if (w_op_done) begin
        case (r_state)
          S_TOMONT:         r_xm   <= mm_result;
          S_SQUARE, S_MULT: r_a    <= mm_result;
          S_FROMMONT:       result <= mm_result;
          default:          ;
        endcase
      end
      if (w_idx_dec) r_idx <= r_idx - IDX_W'(1);
    end
  end

endmodule

// File: tb/tb_modexp_sequencer.sv
// Bench for modexp_sequencer (DATA_W=16, EXP_W=8) with a behavioural Montgomery multiplier
// of random 1..20 cycle latency and a pow-mod golden model feeding a result scoreboard.
module tb_modexp_sequencer;
  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        start = 1'b0;
  logic [15:0] in_x = '0, in_m = '0, in_r2 = '0, in_rmodm = '0;
  logic [7:0]  in_e = '0;
  logic [15:0] result, mm_a, mm_b, mm_m;
  logic        done, busy, mm_start;
  logic [15:0] mm_result = '0;
  logic        mm_done, m_done = 1'b0, spur = 1'b0;

  int vectors = 0, miscompares = 0;
  int done_cnt = 0, start_cnt = 0;
  logic [15:0] sb[$];

  assign mm_done = m_done | spur;

  modexp_sequencer #(.DATA_W(16), .EXP_W(8)) dut (
    .clk(clk), .resetn(resetn), .start(start), .in_x(in_x), .in_e(in_e), .in_m(in_m),
    .in_r2(in_r2), .in_rmodm(in_rmodm), .result(result), .done(done), .busy(busy),
    .mm_start(mm_start), .mm_a(mm_a), .mm_b(mm_b), .mm_m(mm_m),
    .mm_result(mm_result), .mm_done(mm_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // a*b*2^-16 mod m by bitwise Montgomery reduction
  function automatic logic [15:0] mm_f(input logic [15:0] a, b, m);
    longint t;
    t = longint'(a) * longint'(b);
    for (int unsigned i = 0; i < 16; i++) begin
      if (t[0]) t = t + longint'(m);
      t = t >> 1;
    end
    if (t >= longint'(m)) t = t - longint'(m);
    return t[15:0];
  endfunction

  function automatic logic [15:0] powmod(input logic [15:0] x, input logic [7:0] e, input logic [15:0] m);
    longint r, b, mm;
    mm = longint'(m);
    r  = 1 % mm;
    b  = longint'(x) % mm;
    for (int unsigned i = 0; i < 8; i++) begin
      if (e[i]) r = (r * b) % mm;
      b = (b * b) % mm;
    end
    return r[15:0];
  endfunction

  function automatic int exp_ops(input logic [7:0] e);
    int pc = 0, msb = -1;
    for (int i = 0; i < 8; i++) if (e[i]) begin pc++; msb = i; end
`ifdef MODEXP_SKIP_LEADING_ZEROS_EN
    return 2 + (msb + 1) + pc;
`else
    return 2 + 8 + pc + 0 * msb;
`endif
  endfunction

  bit          m_busy = 1'b0;
  int          m_cnt = 0;
  logic [15:0] cap_a = '0, cap_b = '0, cap_m = '0;

  always @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      m_busy = 1'b0;
      m_cnt  = 0;
      m_done <= 1'b0;
    end else begin
      m_done <= 1'b0;
      if (m_busy) begin
        m_cnt--;
        if (m_cnt == 0) begin
          m_done    <= 1'b1;
          mm_result <= mm_f(cap_a, cap_b, cap_m);
          m_busy    = 1'b0;
        end
      end else if (mm_start) begin
        cap_a  = mm_a;
        cap_b  = mm_b;
        cap_m  = mm_m;
        m_cnt  = int'($urandom_range(20, 1));
        m_busy = 1'b1;
      end
    end
  end

  always @(negedge clk) begin
    if (resetn) begin
      if (mm_start) start_cnt++;
      if (m_busy) begin
        chk("mm_operand_stable", {16'h0, mm_a, mm_b, mm_m}, {16'h0, cap_a, cap_b, cap_m});
        chk("one_op_outstanding", mm_start, 0);
      end
      if (done) begin
        done_cnt++;
        chk("done_with_pending_entry", sb.size() > 0, 1);
        if (sb.size() > 0) chk("result", result, sb.pop_front());
      end
    end
  end

  task automatic load(input logic [15:0] x, input logic [7:0] e, input logic [15:0] m);
    longint r2;
    r2       = (longint'(1) << 32) % longint'(m);
    in_x     = x;
    in_e     = e;
    in_m     = m;
    in_r2    = r2[15:0];
    in_rmodm = 16'(32'd65536 % {16'h0, m});
  endtask

  task automatic run(input logic [15:0] x, input logic [7:0] e, input logic [15:0] m,
                     input bit poke_busy, input bit poke_done);
    logic [15:0] exp;
    int d0, s0, c;
    exp = powmod(x, e, m);
    load(x, e, m);
    sb.push_back(exp);
    d0 = done_cnt;
    s0 = start_cnt;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("busy_after_start", busy, 1);
    c = 0;
    while (done !== 1'b1 && c < 3000) begin
      start = poke_busy && (c == 3);
      if (start) load(~x, ~e, m ^ 16'h0002);
      @(negedge clk);
      c++;
    end
    start = 1'b0;
    chk("done_within_budget", c < 3000, 1);
    if (c >= 3000) sb.delete();
    if (poke_done) begin
      load(x ^ 16'h0001, e, m);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      chk("start_in_done_ignored", busy, 0);
      @(negedge clk);
      chk("still_idle_after_done_start", busy, 0);
      chk("result_held", result, exp);
    end else begin
      @(negedge clk);
    end
    chk("done_pulse_count", done_cnt - d0, 1);
    chk("mm_start_count", start_cnt - s0, exp_ops(e));
  endtask

  task automatic chk_all_zero(input string tag);
    chk(tag, {result, mm_a, mm_b, mm_m}, 64'h0);
    chk(tag, {done, busy, mm_start}, 3'b000);
  endtask

  initial begin
    #1_500_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int s0, c;
    logic [15:0] rm;
    repeat (3) @(negedge clk);
    chk_all_zero("reset_state");
    resetn = 1'b1;
    @(negedge clk);

    run(16'd3, 8'd5, 16'd7, 1'b0, 1'b0);
    run(16'd3, 8'd0, 16'd7, 1'b0, 1'b0);
    run(16'd3, 8'd1, 16'd7, 1'b0, 1'b0);
    run(16'd2, 8'hFF, 16'h00F1, 1'b0, 1'b0);
    run(16'd3, 8'd5, 16'd7, 1'b1, 1'b1);

    spur = 1'b1;
    @(negedge clk);
    spur = 1'b0;
    chk("spurious_done_busy", busy, 0);
    chk("spurious_done_mm_start", mm_start, 0);
    @(negedge clk);
    chk("spurious_done_still_idle", busy, 0);
    run(16'd5, 8'd6, 16'd11, 1'b0, 1'b0);

    // abort mid-SQUARE with an asynchronous reset
    load(16'd2, 8'hFF, 16'h00F1);
    sb.push_back(powmod(16'd2, 8'hFF, 16'h00F1));
    s0 = start_cnt;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    c = 0;
    while (start_cnt - s0 < 2 && c < 500) begin
      @(negedge clk);
      c++;
    end
    chk("reached_square", c < 500, 1);
    resetn = 1'b0;
    sb.delete();
    #1;
    chk_all_zero("async_reset_mid_op");
    @(negedge clk);
    chk_all_zero("reset_held_mid_op");
    @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);
    run(16'd2, 8'hFF, 16'h00F1, 1'b0, 1'b0);

    for (int i = 0; i < 200; i++) begin
      rm = 16'($urandom_range(32767, 1) * 2 + 1);
      run(16'($urandom % {16'h0, rm}), 8'($urandom), rm, 1'b0, 1'b0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
